// File: rtl/car_pkg.sv
// Shared definitions for the player car: life-cycle states, keyboard
// codes, road/sprite geometry and motion constants. CAR_W/CAR_H are also
// used by the sprite plotter.
package car_pkg;

   typedef enum logic [1:0] {IDLE, DRIVE, CRASH, RESPAWN} state_t;

   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   localparam int CAR_W    = 47;
   localparam int CAR_H    = 65;
   localparam int X_MIN    = 160;
   localparam int X_MAX    = 480;
   localparam int Y_MIN    = 40;
   localparam int Y_MAX    = 470;
   localparam int X_STEP   = 3;
   localparam int Y_STEP   = 2;
   localparam int X_START  = 296;
   localparam int Y_START  = 400;
   localparam int CRASH_FR = 60;
   localparam int BLINK_FR = 4;

   // Counter bit that flips every BLINK_FR ticks
   localparam int BLINK_BIT = $clog2(BLINK_FR);
   localparam int CNT_W     = $clog2(CRASH_FR + 1);

   // Clamp a signed 11-bit candidate position into [lo, hi]
   function automatic logic [9:0] clamp_pos(input logic signed [10:0] v,
                                            input int lo, input int hi);
      logic [9:0] r;
      if (v < $signed(11'(lo)))
         r = 10'(lo);
      else if (v > $signed(11'(hi)))
         r = 10'(hi);
      else
         r = v[9:0];
      return r;
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on frame_clk (vsync, already synchronous to clk).
// Ports: clk, rst (async, active-high), frame_clk in; tick out, a single
// clk-wide pulse per rising edge. A held-high frame_clk yields one tick.
module frame_tick_gen (
   input  logic clk,
   input  logic rst,
   input  logic frame_clk,
   output logic tick
);

   logic frame_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         frame_q <= 1'b0;
      else
         frame_q <= frame_clk;
   end

   assign tick = frame_clk & ~frame_q;

endmodule

// File: rtl/player_controller.sv
// Player car sequencer. Once per frame tick it moves the car from the
// latched keycode, clamps it to the road, and runs the
// IDLE -> DRIVE -> CRASH -> RESPAWN -> DRIVE life cycle.
// Ports:
//   clk, Reset (async, active-high), frame_clk (vsync), keycode[7:0],
//   collision (level)                              -- inputs
//   PlayerX[9:0], PlayerY[9:0] sprite top-left; player_visible blink gate;
//   crashed; crash_count[7:0] saturating collision count -- outputs
module player_controller
   import car_pkg::*;
(
   input  logic       clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic       collision,
   output logic [9:0] PlayerX,
   output logic [9:0] PlayerY,
   output logic       player_visible,
   output logic       crashed,
   output logic [7:0] crash_count
);

   state_t           state, state_n;
   logic [CNT_W-1:0] count, count_n;
   logic [9:0]       x_n, y_n;
   logic [7:0]       cc_n;
   logic             tick;
   logic signed [10:0] px, py;

   frame_tick_gen u_tick (
      .clk       (clk),
      .rst       (Reset),
      .frame_clk (frame_clk),
      .tick      (tick)
   );

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         PlayerX     <= 10'(X_START);
         PlayerY     <= 10'(Y_START);
         count       <= '0;
         crash_count <= '0;
      end else begin
         state       <= state_n;
         PlayerX     <= x_n;
         PlayerY     <= y_n;
         count       <= count_n;
         crash_count <= cc_n;
      end
   end

   always_comb begin
      state_n = state;
      x_n     = PlayerX;
      y_n     = PlayerY;
      count_n = count;
      cc_n    = crash_count;
      px      = $signed({1'b0, PlayerX});
      py      = $signed({1'b0, PlayerY});
      if (tick) begin
         unique case (state)
            IDLE: begin
               if (keycode == KEY_SPACE)
                  state_n = DRIVE;
            end
            DRIVE: begin
               // Collision wins over movement on the same tick
               if (collision) begin
                  state_n = CRASH;
                  count_n = '0;
                  if (crash_count != '1)
                     cc_n = crash_count + 8'd1;
               end else begin
                  unique case (keycode)
                     KEY_W:   y_n = clamp_pos(py - $signed(11'(Y_STEP)), Y_MIN, Y_MAX - CAR_H);
                     KEY_S:   y_n = clamp_pos(py + $signed(11'(Y_STEP)), Y_MIN, Y_MAX - CAR_H);
                     KEY_A:   x_n = clamp_pos(px - $signed(11'(X_STEP)), X_MIN, X_MAX - CAR_W);
                     KEY_D:   x_n = clamp_pos(px + $signed(11'(X_STEP)), X_MIN, X_MAX - CAR_W);
                     default: ;
                  endcase
               end
            end
            CRASH: begin
               count_n = count + CNT_W'(1);
               if (count == CNT_W'(CRASH_FR - 1))
                  state_n = RESPAWN;
            end
            RESPAWN: begin
               x_n     = 10'(X_START);
               y_n     = 10'(Y_START);
               state_n = DRIVE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Outputs decode registered state only, so they follow a tick by one clk
   always_comb begin
      player_visible = 1'b0;
      crashed        = 1'b0;
      unique case (state)
         IDLE:          player_visible = 1'b0;
         DRIVE:         player_visible = 1'b1;
         CRASH, RESPAWN: begin
            player_visible = ~count[BLINK_BIT];
            crashed        = 1'b1;
         end
         default:       player_visible = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_player_controller.sv
module tb_player_controller;

   logic       clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic [7:0] keycode;
   logic       collision;
   logic [9:0] PlayerX, PlayerY;
   logic       player_visible, crashed;
   logic [7:0] crash_count;

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0 idle, 1 driving, 2 crashed, 3 awaiting respawn
   int m_phase, m_x, m_y, m_since, m_crashes;

   player_controller dut (
      .clk            (clk),
      .Reset          (Reset),
      .frame_clk      (frame_clk),
      .keycode        (keycode),
      .collision      (collision),
      .PlayerX        (PlayerX),
      .PlayerY        (PlayerY),
      .player_visible (player_visible),
      .crashed        (crashed),
      .crash_count    (crash_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_x = 296; m_y = 400; m_since = 0; m_crashes = 0;
   endtask

   function automatic int lim(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task automatic model_tick(input logic [7:0] key, input logic coll);
      case (m_phase)
         0: if (key == 8'h2C) m_phase = 1;
         1: begin
            if (coll) begin
               m_phase = 2; m_since = 0;
               m_crashes = (m_crashes < 255) ? m_crashes + 1 : 255;
            end else begin
               if (key == 8'h1A) m_y = m_y - 2;
               if (key == 8'h16) m_y = m_y + 2;
               if (key == 8'h04) m_x = m_x - 3;
               if (key == 8'h07) m_x = m_x + 3;
               m_x = lim(m_x, 160, 480 - 47);
               m_y = lim(m_y, 40, 470 - 65);
            end
         end
         2: begin
            m_since++;
            if (m_since == 60) m_phase = 3;
         end
         default: begin
            m_x = 296; m_y = 400; m_phase = 1;
         end
      endcase
   endtask

   function automatic int exp_visible();
      if (m_phase == 1) return 1;
      if (m_phase >= 2) return (((m_since / 4) % 2) == 0) ? 1 : 0;
      return 0;
   endfunction

   // Continuous comparison on the inactive edge
   always @(negedge clk) begin
      check("x", int'(PlayerX), m_x);
      check("y", int'(PlayerY), m_y);
      check("visible", int'(player_visible), exp_visible());
      check("crashed", int'(crashed), (m_phase >= 2) ? 1 : 0);
      check("crash_count", int'(crash_count), m_crashes);
   end

   task automatic do_tick(input logic [7:0] key, input logic coll);
      @(negedge clk);
      keycode = key; collision = coll; frame_clk = 1'b1;
      @(posedge clk);
      model_tick(key, coll);
      @(negedge clk);
      frame_clk = 1'b0; collision = 1'b0;
   endtask

   task automatic ticks(input int n, input logic [7:0] key);
      for (int i = 0; i < n; i++) do_tick(key, 1'b0);
   endtask

   initial begin
      Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; collision = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      Reset = 1'b0;

      // Idle with no keys
      ticks(5, 8'h00);
      check("lit_idle_x", int'(PlayerX), 296);
      check("lit_idle_y", int'(PlayerY), 400);
      check("lit_idle_vis", int'(player_visible), 0);

      // Start, then right for 10 frames
      do_tick(8'h2C, 1'b0);
      check("lit_drive_vis", int'(player_visible), 1);
      ticks(10, 8'h07);
      check("lit_d10_x", int'(PlayerX), 326);
      check("lit_d10_y", int'(PlayerY), 400);

      // Drive into every road bound and hold there
      ticks(100, 8'h04);
      check("lit_left_bound", int'(PlayerX), 160);
      ticks(200, 8'h1A);
      check("lit_top_bound", int'(PlayerY), 40);
      ticks(200, 8'h16);
      check("lit_bottom_bound", int'(PlayerY), 405);
      ticks(100, 8'h07);
      check("lit_right_bound", int'(PlayerX), 433);

      // Crash: movement suppressed on the crash tick, keys ignored afterwards
      do_tick(8'h04, 1'b1);
      check("lit_crash_flag", int'(crashed), 1);
      check("lit_crash_count", int'(crash_count), 1);
      check("lit_crash_x", int'(PlayerX), 433);
      check("lit_crash_vis0", int'(player_visible), 1);
      ticks(4, 8'h04);
      check("lit_blink_off", int'(player_visible), 0);
      check("lit_frozen_x", int'(PlayerX), 433);
      ticks(4, 8'h1A);
      check("lit_blink_on", int'(player_visible), 1);
      ticks(52, 8'h00);
      check("lit_respawn_crashed", int'(crashed), 1);
      do_tick(8'h00, 1'b1);   // collision during respawn is ignored
      check("lit_respawn_x", int'(PlayerX), 296);
      check("lit_respawn_y", int'(PlayerY), 400);
      check("lit_respawn_crashed0", int'(crashed), 0);
      check("lit_respawn_vis", int'(player_visible), 1);
      check("lit_respawn_count", int'(crash_count), 1);

      // frame_clk stuck high: exactly one move
      @(negedge clk);
      keycode = 8'h07; frame_clk = 1'b1;
      @(posedge clk);
      model_tick(8'h07, 1'b0);
      repeat (999) @(negedge clk);
      frame_clk = 1'b0;
      @(negedge clk);
      check("lit_held_high_x", int'(PlayerX), 299);

      // Reset in the middle of a crash
      do_tick(8'h00, 1'b1);
      check("lit_crash2_count", int'(crash_count), 2);
      ticks(30, 8'h00);
      @(posedge clk);
      #2 Reset = 1'b1;
      model_reset();
      #1;
      check("lit_rst_x", int'(PlayerX), 296);
      check("lit_rst_y", int'(PlayerY), 400);
      check("lit_rst_vis", int'(player_visible), 0);
      check("lit_rst_crashed", int'(crashed), 0);
      check("lit_rst_count", int'(crash_count), 0);
      @(negedge clk);
      Reset = 1'b0;

      // Back in IDLE: movement keys do nothing until SPACE
      ticks(3, 8'h07);
      check("lit_idle2_x", int'(PlayerX), 296);
      do_tick(8'h2C, 1'b0);
      ticks(2, 8'h16);
      check("lit_after_rst_y", int'(PlayerY), 404);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
